// File: rtl/ring_monitor_6bit.sv
// Receive-side checker for a 6-bit right-rotating one-hot ring: tracks token position,
// counts revolutions and latches a coded error. Define RING_MON_REV_COUNT_EN to build rev_count/rev_wrap.
module ring_monitor_6bit #(
    parameter int REV_W = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [5:0]       ring_in,
    input  logic             en,
    input  logic             ack_err,
    output logic [2:0]       pos,
    output logic             pos_valid,
    output logic [REV_W-1:0] rev_count,
    output logic             rev_wrap,
    output logic             err,
    output logic [1:0]       err_code
);
    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_LOCKED = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] last_q, last_d;
    logic [2:0] pos_q, pos_d;
    logic       pos_valid_q, pos_valid_d;
    logic       err_q, err_d;
    logic [1:0] err_code_q, err_code_d;

    logic [5:0] exp_ring;
    logic       is_zero;
    logic       is_multi;
    logic [2:0] ring_idx;

    assign exp_ring = {last_q[0], last_q[5:1]};
    assign is_zero  = (ring_in == 6'd0);
    assign is_multi = ((ring_in & (ring_in - 6'd1)) != 6'd0);

    always_comb begin
        ring_idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (ring_in[i]) ring_idx = 3'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = ring_in;
        pos_d       = pos_q;
        pos_valid_d = pos_valid_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        unique case (state_q)
            ST_SEARCH: begin
                if (is_multi) begin
                    state_d     = ST_ERROR;
                    err_d       = 1'b1;
                    err_code_d  = 2'b01;
                    pos_valid_d = 1'b0;
                end else if (!is_zero) begin
                    state_d     = ST_LOCKED;
                    pos_d       = ring_idx;
                    pos_valid_d = 1'b1;
                end
            end
            ST_LOCKED: begin
                // 000001 is always a resync; the legal 000010->000001 step has the same effect
                if (is_zero) begin
                    state_d     = ST_SEARCH;
                    pos_valid_d = 1'b0;
                end else if (ring_in == 6'b000001) begin
                    pos_d = 3'd0;
                end else if (is_multi) begin
                    state_d     = ST_ERROR;
                    err_d       = 1'b1;
                    err_code_d  = 2'b01;
                    pos_valid_d = 1'b0;
                end else if (!en && ring_in != last_q) begin
                    state_d     = ST_ERROR;
                    err_d       = 1'b1;
                    err_code_d  = 2'b11;
                    pos_valid_d = 1'b0;
                end else if (!en) begin
                    pos_d = pos_q;
                end else if (ring_in == exp_ring) begin
                    pos_d = ring_idx;
                end else if (ring_in != last_q) begin
                    state_d     = ST_ERROR;
                    err_d       = 1'b1;
                    err_code_d  = 2'b10;
                    pos_valid_d = 1'b0;
                end
            end
            default: begin
                last_d      = last_q;
                pos_valid_d = 1'b0;
                if (ack_err) begin
                    state_d    = ST_SEARCH;
                    err_d      = 1'b0;
                    err_code_d = 2'b00;
                    last_d     = ring_in;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= ST_SEARCH;
            last_q      <= 6'd0;
            pos_q       <= 3'd0;
            pos_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            pos_q       <= pos_d;
            pos_valid_q <= pos_valid_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign pos       = pos_q;
    assign pos_valid = pos_valid_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

`ifdef RING_MON_REV_COUNT_EN
    logic [REV_W-1:0] rev_count_q, rev_count_d;
    logic             rev_wrap_q, rev_wrap_d;
    logic             rev_step;

    // A revolution completes on the legal 000001 -> 100000 step
    assign rev_step = (state_q == ST_LOCKED) && en &&
                      (last_q == 6'b000001) && (ring_in == 6'b100000);

    always_comb begin
        rev_count_d = rev_count_q + {{(REV_W-1){1'b0}}, rev_step};
        rev_wrap_d  = rev_step && (rev_count_q == {REV_W{1'b1}});
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            rev_count_q <= '0;
            rev_wrap_q  <= 1'b0;
        end else begin
            rev_count_q <= rev_count_d;
            rev_wrap_q  <= rev_wrap_d;
        end
    end

    assign rev_count = rev_count_q;
    assign rev_wrap  = rev_wrap_q;
`else
    assign rev_count = '0;
    assign rev_wrap  = 1'b0;
`endif
endmodule
